// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its built-in self-test sequencer:
// opcode encoding, datapath widths and the sweep length.
package alu_pkg;

  localparam int ALU_W   = 4;
  localparam int RES_W   = 8;
  localparam int OP_W    = 3;
  localparam int NUM_VEC = 2048;
  localparam int IDX_W   = 11;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_MUL = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/alu_selftest_seq_if.sv
// ALU operand/result bus. The self-test sequencer is the master (drives
// operands, receives the result); the ALU is the slave.
interface alu_selftest_seq_if;
  import alu_pkg::*;

  logic [ALU_W-1:0] a_o;
  logic [ALU_W-1:0] b_o;
  alu_op_t          op_o;
  logic [RES_W-1:0] result_i;

  modport master (output a_o, b_o, op_o, input result_i);
  modport slave  (input a_o, b_o, op_o, output result_i);

endinterface

// File: rtl/alu_ref_model.sv
// Combinational golden model of the 4-bit ALU: (A, B, op) -> zero-extended
// 8-bit result.
module alu_ref_model
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  alu_op_t          op,
  output logic [RES_W-1:0] result
);

  logic [RES_W-1:0] a_ext;
  logic [RES_W-1:0] b_ext;

  assign a_ext = {{(RES_W-ALU_W){1'b0}}, a};
  assign b_ext = {{(RES_W-ALU_W){1'b0}}, b};

  always_comb begin
    result = '0;
    case (op)
      OP_ADD: result = a_ext + b_ext;
      // Wraps modulo 256 naturally in the 8-bit result width.
      OP_SUB: result = a_ext - b_ext;
      OP_AND: result = a_ext & b_ext;
      OP_OR:  result = a_ext | b_ext;
      OP_XOR: result = a_ext ^ b_ext;
      OP_NOT: result = {{(RES_W-ALU_W){1'b0}}, ~a};
      OP_SHL: result = {{(RES_W-ALU_W-1){1'b0}}, a, 1'b0};
      OP_MUL: result = a_ext * b_ext;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_selftest_seq.sv
// BIST sequencer: sweeps all 2048 (A, B, op) vectors into the ALU, compares
// each result after LATENCY cycles and records error count and first failure.
module alu_selftest_seq
  import alu_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  alu_selftest_seq_if.master alu,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [RES_W-1:0]   err_cnt,
  output logic [IDX_W-1:0]   first_fail
);

  localparam int               CNT_W     = 2;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(LATENCY);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_VEC - 1);

  seq_state_t       state_q;
  seq_state_t       state_d;
  logic             start_q;
  logic             start_acc;
  logic             sweep_clr;
  logic             cmp_en;
  logic             mismatch;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] wait_q;
  logic [RES_W-1:0] exp_res;
  alu_op_t          cur_op;

  function automatic logic [RES_W-1:0] sat_inc(input logic [RES_W-1:0] v);
    return (v == '1) ? v : v + RES_W'(1);
  endfunction

  assign cur_op = alu_op_t'(idx_q[IDX_W-1:2*ALU_W]);

  alu_ref_model u_ref (
    .a      (idx_q[ALU_W-1:0]),
    .b      (idx_q[2*ALU_W-1:ALU_W]),
    .op     (cur_op),
    .result (exp_res)
  );

  // Only a rising edge of start is accepted, so a long start pulse runs one sweep.
  assign start_acc = start & ~start_q;

  always_comb begin
    state_d   = state_q;
    sweep_clr = 1'b0;
    cmp_en    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_acc) begin
          state_d   = ST_APPLY;
          sweep_clr = 1'b1;
        end
      end
      ST_APPLY: begin
        cmp_en = (wait_q == WAIT_LAST);
        if (cmp_en && (idx_q == IDX_LAST)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mismatch = cmp_en && (alu.result_i != exp_res);

  assign busy     = (state_q == ST_APPLY);
  assign done     = (state_q == ST_DONE);
  assign pass     = done && (err_cnt == '0);
  assign alu.a_o  = busy ? idx_q[ALU_W-1:0]       : '0;
  assign alu.b_o  = busy ? idx_q[2*ALU_W-1:ALU_W] : '0;
  assign alu.op_o = busy ? cur_op                 : OP_ADD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
    end
  end

  // Vector walk and error capture; error registers hold through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      wait_q     <= '0;
      err_cnt    <= '0;
      first_fail <= '0;
    end else if (sweep_clr) begin
      idx_q      <= '0;
      wait_q     <= '0;
      err_cnt    <= '0;
      first_fail <= '0;
    end else if (state_q == ST_APPLY) begin
      if (cmp_en) begin
        wait_q <= '0;
        if (idx_q != IDX_LAST) idx_q <= idx_q + IDX_W'(1);
        if (mismatch) begin
          err_cnt <= sat_inc(err_cnt);
          if (err_cnt == '0) first_fail <= idx_q;
        end
      end else begin
        wait_q <= wait_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_selftest_seq.sv
// Bench for alu_selftest_seq: behavioural ALU stubs (latency 1 and 2) with
// injectable faults drive two sequencer instances through directed sweeps.
module tb_alu_selftest_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start1, start2;
  logic        busy1, done1, pass1, busy2, done2, pass2;
  logic [7:0]  err1, err2;
  logic [10:0] ff1, ff2;
  logic [10:0] vec1, vec2;
  logic [7:0]  res1_p0, res2_p0, res2_p1;

  logic [7:0]  flip [0:2047];
  logic        fault_stuck;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_selftest_seq_if if1 ();
  alu_selftest_seq_if if2 ();

  alu_selftest_seq #(.LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .alu(if1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .first_fail(ff1)
  );

  alu_selftest_seq #(.LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .alu(if2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .first_fail(ff2)
  );

  assign vec1 = {if1.op_o, if1.b_o, if1.a_o};
  assign vec2 = {if2.op_o, if2.b_o, if2.a_o};

  // Expected ALU behaviour from the operation table, with plain integer arithmetic.
  function automatic logic [7:0] ref_res(input int idx);
    int a, b, op, r;
    a  = idx & 15;
    b  = (idx >> 4) & 15;
    op = (idx >> 8) & 7;
    case (op)
      0: r = a + b;
      1: r = (a - b) & 255;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 15 - a;
      6: r = a * 2;
      default: r = a * b;
    endcase
    return 8'(r);
  endfunction

  function automatic logic [7:0] stub_out(input int idx);
    if (fault_stuck) return 8'h00;
    return ref_res(idx) ^ flip[idx];
  endfunction

  always @(posedge clk) res1_p0 <= stub_out(int'(vec1));
  always @(posedge clk) begin
    res2_p0 <= stub_out(int'(vec2));
    res2_p1 <= res2_p0;
  end
  assign if1.result_i = res1_p0;
  assign if2.result_i = res2_p1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic g_busy(input int s); return (s == 0) ? busy1 : busy2; endfunction
  function automatic logic g_done(input int s); return (s == 0) ? done1 : done2; endfunction
  function automatic logic g_pass(input int s); return (s == 0) ? pass1 : pass2; endfunction
  function automatic logic [7:0] g_err(input int s); return (s == 0) ? err1 : err2; endfunction
  function automatic logic [10:0] g_ff(input int s); return (s == 0) ? ff1 : ff2; endfunction
  function automatic logic [10:0] g_vec(input int s); return (s == 0) ? vec1 : vec2; endfunction

  task automatic set_start(input int s, input logic v);
    if (s == 0) start1 = v; else start2 = v;
  endtask

  task automatic clear_faults();
    fault_stuck = 1'b0;
    for (int i = 0; i < 2048; i++) flip[i] = 8'h00;
  endtask

  // Scoreboard over the whole vector space for the current stub fault setup.
  task automatic compute_expect(output int e_err, output int e_ff);
    e_err = 0;
    e_ff  = 0;
    for (int i = 0; i < 2048; i++) begin
      if (stub_out(i) !== ref_res(i)) begin
        if (e_err == 0) e_ff = i;
        e_err++;
      end
    end
    if (e_err > 255) e_err = 255;
  endtask

  task automatic sweep_and_check(input string tag, input int s, input int hold,
                                 input int restart_at);
    int per, e_err, e_ff, busy_cyc, stab_bad;
    logic [7:0] err_at0;
    logic done_at0;
    per = (s == 0) ? 2 : 3;
    compute_expect(e_err, e_ff);
    busy_cyc = 0;
    stab_bad = 0;
    err_at0  = 8'hxx;
    done_at0 = 1'bx;
    @(negedge clk);
    set_start(s, 1'b1);
    @(posedge clk);
    for (int k = 0; k < 2048 * per + 64; k++) begin
      @(negedge clk);
      if (k == hold - 1) set_start(s, 1'b0);
      if (k == restart_at) set_start(s, 1'b1);
      if (k == restart_at + 1) set_start(s, 1'b0);
      if (k == 0) begin
        err_at0  = g_err(s);
        done_at0 = g_done(s);
      end
      if (!g_busy(s)) break;
      if (int'(g_vec(s)) != k / per) stab_bad++;
      busy_cyc++;
    end
    set_start(s, 1'b0);
    check({tag, "_err_clr_at_start"}, 32'(err_at0), 0);
    check({tag, "_done_clr_at_start"}, 32'(done_at0), 0);
    check({tag, "_busy_cycles"}, busy_cyc, 2048 * per);
    check({tag, "_vector_order"}, stab_bad, 0);
    check({tag, "_done"}, 32'(g_done(s)), 1);
    check({tag, "_busy_low"}, 32'(g_busy(s)), 0);
    check({tag, "_err_cnt"}, 32'(g_err(s)), e_err);
    check({tag, "_first_fail"}, 32'(g_ff(s)), e_ff);
    check({tag, "_pass"}, 32'(g_pass(s)), (e_err == 0) ? 1 : 0);
    check({tag, "_idle_ops"}, 32'(g_vec(s)), 0);
    repeat (5) @(negedge clk);
    check({tag, "_done_sticky"}, 32'(g_done(s)), 1);
    check({tag, "_err_hold"}, 32'(g_err(s)), e_err);
    check({tag, "_ff_hold"}, 32'(g_ff(s)), e_ff);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy1"}, 32'(busy1), 0);
    check({tag, "_done1"}, 32'(done1), 0);
    check({tag, "_pass1"}, 32'(pass1), 0);
    check({tag, "_err1"}, 32'(err1), 0);
    check({tag, "_ff1"}, 32'(ff1), 0);
    check({tag, "_ops1"}, 32'(vec1), 0);
    check({tag, "_busy2"}, 32'(busy2), 0);
    check({tag, "_done2"}, 32'(done2), 0);
    check({tag, "_pass2"}, 32'(pass2), 0);
    check({tag, "_err2"}, 32'(err2), 0);
    check({tag, "_ops2"}, 32'(vec2), 0);
  endtask

  initial begin
    int n_flt, wait_cyc, fi;
    rst_n  = 1'b1;
    start1 = 1'b0;
    start2 = 1'b0;
    clear_faults();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Clean sweep with a healthy ALU.
    sweep_and_check("clean", 0, 1, 100000);

    // Start held for 3 cycles plus a second pulse mid-sweep; both ignored.
    sweep_and_check("restart_ign", 0, 3, 1990 + int'($urandom_range(0, 20)));

    // Single bit-0 flip at idx 5.
    flip[5] = 8'h01;
    sweep_and_check("flip5", 0, 1, 100000);
    check("flip5_ff_direct", 32'(ff1), 5);
    check("flip5_err_direct", 32'(err1), 1);
    clear_faults();

    // A few random faulty vectors with random corruption masks.
    n_flt = int'($urandom_range(2, 4));
    for (int i = 0; i < n_flt; i++) begin
      fi = int'($urandom_range(0, 2047));
      flip[fi] = 8'($urandom_range(1, 255));
    end
    sweep_and_check("rand_flt", 0, 1, 100000);
    clear_faults();

    // Result stuck at zero: saturated count, first nonzero expectation at idx 1.
    fault_stuck = 1'b1;
    sweep_and_check("stuck0", 0, 1, 100000);
    check("stuck0_err_sat", 32'(err1), 255);
    check("stuck0_ff_direct", 32'(ff1), 1);

    // Asynchronous reset in the middle of a failing sweep.
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_cyc = int'($urandom_range(500, 3000));
    repeat (wait_cyc) @(negedge clk);
    check("midrst_pre_busy", 32'(busy1), 1);
    check("midrst_pre_err_nz", 32'(err1 != 8'h00), 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    clear_faults();
    sweep_and_check("after_rst", 0, 1, 100000);

    // Two-stage ALU with LATENCY=2: three cycles per vector.
    sweep_and_check("lat2", 1, 1, 100000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
